// File: rtl/atpg_ctrl_pkg.sv
// Shared types and default constants for the ATPG test-mode entry/exit sequencer.
// Contents: FSM state enum and width, default unlock key, debounce and exit filter lengths.
package atpg_ctrl_pkg;

    localparam int unsigned STATE_W      = 3;
    localparam int unsigned KEY_W_DEF    = 16;
    localparam logic [15:0] KEY_VAL_DEF  = 16'h1127;
    localparam int unsigned DEB_CYC_DEF  = 8;
    localparam int unsigned EXIT_CYC_DEF = 16;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE = 3'd0,
        ST_KEY  = 3'd1,
        ST_ARM  = 3'd2,
        ST_SCAN = 3'd3,
        ST_EXIT = 3'd4,
        ST_LOCK = 3'd5
    } state_e;

endpackage

// File: rtl/atpg_sync2.sv
// Two-flop synchronizer with asynchronous active-low reset (output resets to 0).
// Ports: clk, rstz, d (asynchronous input), q (synchronized output).
module atpg_sync2 (
    input  logic clk,
    input  logic rstz,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge rstz) begin
        if (!rstz) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/atpg_mode_ctrl.sv
// ATPG test-mode sequencer: qualifies TST plus a serial unlock key before asserting
// scan_mode, filters TST-low for scan exit and requests a functional reset on exit.
// Ports: clk, rstz, tst_pin (async), key_vld/key_bit (serial key), se_pin (pad SE);
//        scan_mode, scan_en (combinational), pad_so_oe, core_rst_req, key_err,
//        key_lock, state_o (debug).
// Config macro ATPG_LOCK_EN: adds a fail counter; the third wrong key locks out
// key entry until reset. Undefined: LOCK unreachable and key_lock tied 0.
module atpg_mode_ctrl
    import atpg_ctrl_pkg::*;
#(
    parameter int unsigned      KEY_W    = KEY_W_DEF,
    parameter logic [KEY_W-1:0] KEY_VAL  = KEY_W'(KEY_VAL_DEF),
    parameter int unsigned      DEB_CYC  = DEB_CYC_DEF,
    parameter int unsigned      EXIT_CYC = EXIT_CYC_DEF
) (
    input  logic               clk,
    input  logic               rstz,
    input  logic               tst_pin,
    input  logic               key_vld,
    input  logic               key_bit,
    input  logic               se_pin,
    output logic               scan_mode,
    output logic               scan_en,
    output logic               pad_so_oe,
    output logic               core_rst_req,
    output logic               key_err,
    output logic               key_lock,
    output logic [STATE_W-1:0] state_o
);

    localparam int unsigned KCNT_W = $clog2(KEY_W + 1);
    localparam int unsigned DCNT_W = $clog2(DEB_CYC + 1);
    localparam int unsigned ECNT_W = $clog2(EXIT_CYC + 1);

    state_e            state_q, state_d;
    logic              tst_s;
    logic              tst_prev_q, tst_prev_d;
    logic              tst_rise;
    logic [KEY_W-1:0]  key_sr_q, key_sr_d;
    logic [KCNT_W-1:0] key_cnt_q, key_cnt_d;
    logic [DCNT_W-1:0] deb_cnt_q, deb_cnt_d;
    logic [ECNT_W-1:0] exit_cnt_q, exit_cnt_d;
    logic              scan_mode_q, scan_mode_d;
    logic              pad_so_oe_q, pad_so_oe_d;
    logic              core_rst_req_q, core_rst_req_d;
    logic              key_err_q, key_err_d;
`ifdef ATPG_LOCK_EN
    logic [1:0]        fail_cnt_q, fail_cnt_d;
    logic              key_lock_q, key_lock_d;
`endif

    // TST pad synchronizer
    atpg_sync2 u_tst_sync (
        .clk  (clk),
        .rstz (rstz),
        .d    (tst_pin),
        .q    (tst_s)
    );

    assign tst_rise = tst_s & ~tst_prev_q;

    // State and datapath registers
    always_ff @(posedge clk or negedge rstz) begin
        if (!rstz) begin
            state_q        <= ST_IDLE;
            tst_prev_q     <= 1'b0;
            key_sr_q       <= '0;
            key_cnt_q      <= '0;
            deb_cnt_q      <= '0;
            exit_cnt_q     <= '0;
            scan_mode_q    <= 1'b0;
            pad_so_oe_q    <= 1'b0;
            core_rst_req_q <= 1'b0;
            key_err_q      <= 1'b0;
`ifdef ATPG_LOCK_EN
            fail_cnt_q     <= '0;
            key_lock_q     <= 1'b0;
`endif
        end else begin
            state_q        <= state_d;
            tst_prev_q     <= tst_prev_d;
            key_sr_q       <= key_sr_d;
            key_cnt_q      <= key_cnt_d;
            deb_cnt_q      <= deb_cnt_d;
            exit_cnt_q     <= exit_cnt_d;
            scan_mode_q    <= scan_mode_d;
            pad_so_oe_q    <= pad_so_oe_d;
            core_rst_req_q <= core_rst_req_d;
            key_err_q      <= key_err_d;
`ifdef ATPG_LOCK_EN
            fail_cnt_q     <= fail_cnt_d;
            key_lock_q     <= key_lock_d;
`endif
        end
    end

    // Next-state, counters and registered-output decode
    always_comb begin
        state_d    = state_q;
        tst_prev_d = tst_s;
        key_sr_d   = key_sr_q;
        key_cnt_d  = key_cnt_q;
        deb_cnt_d  = deb_cnt_q;
        exit_cnt_d = exit_cnt_q;
        key_err_d  = 1'b0;
`ifdef ATPG_LOCK_EN
        fail_cnt_d = fail_cnt_q;
`endif

        unique case (state_q)
            ST_IDLE: begin
                if (tst_rise) begin
                    state_d   = ST_KEY;
                    key_sr_d  = '0;
                    key_cnt_d = '0;
                end
            end
            ST_KEY: begin
                // TST loss beats both the compare and a last key bit
                if (!tst_s) begin
                    state_d = ST_IDLE;
                end else if (key_cnt_q == KCNT_W'(KEY_W)) begin
                    if (key_sr_q == KEY_VAL) begin
                        state_d   = ST_ARM;
                        deb_cnt_d = '0;
`ifdef ATPG_LOCK_EN
                        fail_cnt_d = '0;
`endif
                    end else begin
                        key_err_d = 1'b1;
`ifdef ATPG_LOCK_EN
                        fail_cnt_d = fail_cnt_q + 2'd1;
                        state_d    = (fail_cnt_q == 2'd2) ? ST_LOCK : ST_IDLE;
`else
                        state_d    = ST_IDLE;
`endif
                    end
                end else if (key_vld) begin
                    key_sr_d  = {key_sr_q[KEY_W-2:0], key_bit};
                    key_cnt_d = key_cnt_q + KCNT_W'(1);
                end
            end
            ST_ARM: begin
                if (!tst_s) begin
                    state_d = ST_IDLE;
                end else if (deb_cnt_q == DCNT_W'(DEB_CYC - 1)) begin
                    state_d    = ST_SCAN;
                    exit_cnt_d = '0;
                end else begin
                    deb_cnt_d = deb_cnt_q + DCNT_W'(1);
                end
            end
            ST_SCAN: begin
                // Exit needs EXIT_CYC consecutive low samples
                if (tst_s) begin
                    exit_cnt_d = '0;
                end else if (exit_cnt_q == ECNT_W'(EXIT_CYC - 1)) begin
                    state_d = ST_EXIT;
                end else begin
                    exit_cnt_d = exit_cnt_q + ECNT_W'(1);
                end
            end
            ST_EXIT: begin
                state_d = ST_IDLE;
            end
`ifdef ATPG_LOCK_EN
            ST_LOCK: begin
                state_d = ST_LOCK;
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        scan_mode_d    = (state_d == ST_SCAN);
        pad_so_oe_d    = (state_d == ST_SCAN);
        core_rst_req_d = (state_d == ST_EXIT);
`ifdef ATPG_LOCK_EN
        key_lock_d     = (state_d == ST_LOCK);
`endif
    end

    assign scan_mode    = scan_mode_q;
    assign pad_so_oe    = pad_so_oe_q;
    assign core_rst_req = core_rst_req_q;
    assign key_err      = key_err_q;
    assign state_o      = state_q;
    // Pad SE reaches the core unregistered so ATPG timing is set at the pad
    assign scan_en      = scan_mode_q & se_pin;
`ifdef ATPG_LOCK_EN
    assign key_lock     = key_lock_q;
`else
    assign key_lock     = 1'b0;
`endif

endmodule

// File: tb/tb_atpg_mode_ctrl.sv
// Directed self-checking bench for atpg_mode_ctrl.
module tb_atpg_mode_ctrl;

    logic       clk;
    logic       rstz;
    logic       tst_pin;
    logic       key_vld;
    logic       key_bit;
    logic       se_pin;
    logic       scan_mode;
    logic       scan_en;
    logic       pad_so_oe;
    logic       core_rst_req;
    logic       key_err;
    logic       key_lock;
    logic [2:0] state_o;

    int n_checks = 0;
    int n_errors = 0;
    int n_kerr   = 0;
    int n_rst    = 0;

    localparam logic [15:0] GOOD_KEY = 16'h1127;
    localparam logic [15:0] BAD_KEY  = 16'h1128;

    atpg_mode_ctrl dut (
        .clk          (clk),
        .rstz         (rstz),
        .tst_pin      (tst_pin),
        .key_vld      (key_vld),
        .key_bit      (key_bit),
        .se_pin       (se_pin),
        .scan_mode    (scan_mode),
        .scan_en      (scan_en),
        .pad_so_oe    (pad_so_oe),
        .core_rst_req (core_rst_req),
        .key_err      (key_err),
        .key_lock     (key_lock),
        .state_o      (state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse counters sampled mid-cycle
    always @(negedge clk) begin
        if (key_err === 1'b1)      n_kerr++;
        if (core_rst_req === 1'b1) n_rst++;
    end

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_bits(input logic [15:0] key, input int first, input int last);
        for (int i = first; i <= last; i++) begin
            key_bit = key[15-i];
            key_vld = 1'b1;
            tick(1);
            key_vld = 1'b0;
        end
        key_bit = 1'b0;
    endtask

    // Pad rise is seen by the FSM on the third edge
    task automatic raise_tst();
        tst_pin = 1'b1;
        tick(3);
    endtask

    task automatic drop_tst();
        tst_pin = 1'b0;
        tick(4);
    endtask

    task automatic enter_scan();
        raise_tst();
        send_bits(GOOD_KEY, 0, 15);
        tick(1);
        tick(8);
    endtask

    initial begin
        rstz    = 1'b0;
        tst_pin = 1'b0;
        key_vld = 1'b0;
        key_bit = 1'b0;
        se_pin  = 1'b1;
        tick(3);

        // Reset state
        check("rst_state", 16'(state_o), 16'd0);
        check("rst_outs", {10'd0, scan_mode, scan_en, pad_so_oe, core_rst_req, key_err, key_lock}, 16'd0);
        rstz   = 1'b1;
        se_pin = 1'b0;
        tick(2);

        // Clean entry
        tst_pin = 1'b1;
        tick(2);
        check("sync_lat_2", 16'(state_o), 16'd0);
        tick(1);
        check("sync_lat_3", 16'(state_o), 16'd1);
        send_bits(GOOD_KEY, 0, 15);
        check("key_full", 16'(state_o), 16'd1);
        key_bit = 1'b1;
        key_vld = 1'b1;
        tick(1);
        key_vld = 1'b0;
        check("arm_enter", 16'(state_o), 16'd2);
        tick(7);
        check("arm_hold", {15'd0, scan_mode}, 16'd0);
        check("arm_state7", 16'(state_o), 16'd2);
        tick(1);
        check("scan_state", 16'(state_o), 16'd3);
        check("scan_mode", {15'd0, scan_mode}, 16'd1);
        check("pad_so_oe", {15'd0, pad_so_oe}, 16'd1);
        se_pin = 1'b1;
        #1;
        check("se_hi", {15'd0, scan_en}, 16'd1);
        se_pin = 1'b0;
        #1;
        check("se_lo", {15'd0, scan_en}, 16'd0);
        key_vld = 1'b1;
        tick(2);
        key_vld = 1'b0;
        check("scan_kvld_ign", 16'(state_o), 16'd3);

        // Exit filter: 15 low cycles do not exit
        tst_pin = 1'b0;
        tick(15);
        tst_pin = 1'b1;
        tick(20);
        check("exit15_state", 16'(state_o), 16'd3);
        check("exit15_norst", 16'(n_rst), 16'd0);

        // Exit filter: 16 low cycles exit
        tst_pin = 1'b0;
        tick(17);
        check("exit16_pre", 16'(state_o), 16'd3);
        tick(1);
        check("exit_state", 16'(state_o), 16'd4);
        check("exit_outs", {13'd0, scan_mode, pad_so_oe, core_rst_req}, 16'd1);
        tick(1);
        check("exit_idle", 16'(state_o), 16'd0);
        check("exit_rst_cnt", 16'(n_rst), 16'd1);
        tick(2);

        // Wrong key
        raise_tst();
        send_bits(BAD_KEY, 0, 15);
        tick(1);
        check("bad_state", 16'(state_o), 16'd0);
        check("bad_kerr", {15'd0, key_err}, 16'd1);
        tick(1);
        check("bad_kerr_pulse", {15'd0, key_err}, 16'd0);
        check("bad_kerr_cnt", 16'(n_kerr), 16'd1);
        check("bad_nosm", {15'd0, scan_mode}, 16'd0);
        drop_tst();

        // Abort after 10 bits
        raise_tst();
        send_bits(GOOD_KEY, 0, 9);
        tst_pin = 1'b0;
        tick(3);
        check("abort_key", 16'(state_o), 16'd0);
        tick(2);

        // Abort during ARM
        raise_tst();
        send_bits(GOOD_KEY, 0, 15);
        tick(3);
        tst_pin = 1'b0;
        tick(2);
        check("abort_arm_pre", 16'(state_o), 16'd2);
        tick(1);
        check("abort_arm", 16'(state_o), 16'd0);
        check("abort_arm_sm", {15'd0, scan_mode}, 16'd0);
        tick(2);

        // TST fall on the same edge as the 16th bit
        raise_tst();
        send_bits(GOOD_KEY, 0, 12);
        tst_pin = 1'b0;
        send_bits(GOOD_KEY, 13, 15);
        check("simul_state", 16'(state_o), 16'd0);
        tick(3);
        check("simul_state2", 16'(state_o), 16'd0);
        check("abort_kerr_cnt", 16'(n_kerr), 16'd1);
        check("abort_nosm", {15'd0, scan_mode}, 16'd0);

        // Reset mid-scan
        enter_scan();
        check("rescan_state", 16'(state_o), 16'd3);
        se_pin = 1'b1;
        #1;
        check("rescan_se", {15'd0, scan_en}, 16'd1);
        tst_pin = 1'b0;
        rstz    = 1'b0;
        #1;
        check("rstmid_state", 16'(state_o), 16'd0);
        check("rstmid_outs", {10'd0, scan_mode, scan_en, pad_so_oe, core_rst_req, key_err, key_lock}, 16'd0);
        tick(2);
        rstz   = 1'b1;
        se_pin = 1'b0;
        tick(3);
        check("rstmid_norst", 16'(n_rst), 16'd1);

        // Three wrong keys, then the correct one
        for (int a = 0; a < 3; a++) begin
            raise_tst();
            send_bits(BAD_KEY, 0, 15);
            tick(1);
            drop_tst();
        end
        check("lock_kerr_cnt", 16'(n_kerr), 16'd4);
`ifdef ATPG_LOCK_EN
        check("lock_state", 16'(state_o), 16'd5);
        check("lock_flag", {15'd0, key_lock}, 16'd1);
        raise_tst();
        send_bits(GOOD_KEY, 0, 15);
        tick(10);
        check("lock_hold", 16'(state_o), 16'd5);
        check("lock_nosm", {15'd0, scan_mode}, 16'd0);
`else
        check("nolock_state", 16'(state_o), 16'd0);
        check("nolock_flag", {15'd0, key_lock}, 16'd0);
        raise_tst();
        send_bits(GOOD_KEY, 0, 15);
        tick(9);
        check("nolock_scan", 16'(state_o), 16'd3);
        check("nolock_sm", {15'd0, scan_mode}, 16'd1);
`endif
        tst_pin = 1'b0;
        rstz    = 1'b0;
        #1;
        check("final_state", 16'(state_o), 16'd0);
        check("final_lock", {15'd0, key_lock}, 16'd0);
        tick(2);
        rstz = 1'b1;
        tick(2);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/atpg_mode_ctrl.md
Name: atpg_mode_ctrl

Overview:
Test-mode entry/exit sequencer for the chip top. Qualifies the TST pin plus a serial unlock key before asserting scan_mode, which reconfigures the pads (GPIO/SCL/SDA) as scan-in/out and scan-enable for ATPG. Gates pad scan-enable into the core and requests a functional reset on scan exit. Sits beside the pad mux in the chip top; its outputs drive the pad-mux selects and the core DFT controls.

Parameters:
KEY_W, 16, unlock key length in bits
KEY_VAL, 16'h1127, required unlock key, MSB first
DEB_CYC, 8, cycles TST must stay high after key match before entering scan
EXIT_CYC, 16, consecutive TST-low cycles required to leave scan

Ports:
clk  in  1  system clock
rstz  in  1  asynchronous active-low reset
tst_pin  in  1  raw TST pad input, asynchronous
key_vld  in  1  one-cycle strobe, key_bit valid (clk domain)
key_bit  in  1  serial key data
se_pin  in  1  pad scan-enable (GPIO_TS), used only in scan
scan_mode  out  1  pad mux / DFT mode select
scan_en  out  1  core scan-enable
pad_so_oe  out  1  output enable for scan-out pads
core_rst_req  out  1  one-cycle pulse requesting functional reset
key_err  out  1  one-cycle pulse on wrong key
key_lock  out  1  key entry locked (optional feature)
state_o  out  3  current FSM state, for debug/observe

Behaviour:
- One clock; reset is asynchronous and active-low: clk, rstz. Reset values: state IDLE; scan_mode=0, pad_so_oe=0, core_rst_req=0, key_err=0, key_lock=0, state_o=0. scan_en=0 follows because scan_mode=0.
- tst_pin passes through a 2-flop synchronizer (reset to 0) to give tst_s. tst_s rise detection is 3 cycles after the pad edge.
- IDLE: on tst_s rising edge -> KEY; clear the key shift register and the bit counter (width clog2(KEY_W+1)).
- KEY:
  - Each key_vld shifts key_bit into the LSB (MSB-first entry) and increments the count.
  - The cycle after count reaches KEY_W, the register is compared:
    - match -> ARM;
    - mismatch -> IDLE with a key_err pulse.
  - Bits beyond KEY_W are never accepted (compare occurs first).
  - tst_s low in KEY -> IDLE, no key_err. This wins over a simultaneous last bit or compare.
- ARM: counts DEB_CYC cycles with tst_s high, then -> SCAN. tst_s low at any point -> IDLE, no error.
- SCAN:
  - scan_mode=1 and pad_so_oe=1, both registered and set on SCAN entry.
  - scan_en = scan_mode & se_pin, combinational with no register, so ATPG shift/capture timing comes straight from the pad.
  - key_vld is ignored.
  - Exit counter increments on each tst_s=0 cycle and clears on any tst_s=1. Reaching EXIT_CYC -> EXIT.
- EXIT: for one cycle, scan_mode=0, pad_so_oe=0 and core_rst_req=1; then -> IDLE. A new tst_s rise during EXIT is ignored. Re-entry requires TST to go low and then high again from IDLE.
- key_vld is ignored in IDLE, ARM, SCAN and EXIT.
- rstz assertion in any state (including mid-scan) forces reset values immediately; no core_rst_req is issued.
- state_o encoding: IDLE=0, KEY=1, ARM=2, SCAN=3, EXIT=4, LOCK=5.

Optional Feature:
ATPG_LOCK_EN.
- Defined:
  - A 2-bit fail counter, reset 0, increments on each key_err.
  - The third failure moves to LOCK instead of IDLE.
  - LOCK sets key_lock=1 and ignores tst_s and key_vld until rstz.
  - The counter clears on successful entry to ARM.
- Undefined: no counter, LOCK unreachable, key_lock tied 0.

Decomposition:
- Package atpg_ctrl_pkg: state enum (values above), state width constant 3, default KEY_VAL and KEY_W constants.
- One sub-module, atpg_sync2: a 2-flop async-reset synchronizer used for tst_pin.
- Counters and FSM stay in atpg_mode_ctrl.

Test Plan:
- Clean entry: reset, tst_pin=1, shift 16'h1127 MSB-first, hold TST -> key match, ARM for 8 cycles, scan_mode=1 and pad_so_oe=1; toggle se_pin and check scan_en follows the same cycle.
- Wrong key: shift 16'h1128 -> single key_err pulse, state_o returns to 0, scan_mode stays 0.
- Exit filter:
  - in SCAN, drop TST for 15 cycles then raise it -> stays in SCAN;
  - drop for 16 cycles -> one core_rst_req pulse with scan_mode=0, then IDLE.
- Abort: drop TST after 10 key bits, and separately during ARM -> IDLE, no key_err, no scan_mode; simultaneous TST fall with the 16th bit -> IDLE.
- Reset mid-scan: assert rstz low in SCAN -> all outputs 0 immediately, state_o=0, no core_rst_req.
- With ATPG_LOCK_EN: three wrong keys -> key_lock=1 and state_o=5; a correct key is then ignored until rstz. Without the macro: key_lock stays 0 and the fourth attempt with the correct key enters SCAN.
